// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: writeback select, opcodes, hazard-control FSM states and
// operand-usage decode helpers.
package rv32_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } WBSel_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    HZ_RUN,
    HZ_MEM_WAIT
  } hz_state_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous active-high clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: load-use bubbles, EX redirect flushes, data-memory freeze,
// plus saturating stall/flush statistics and a sticky memory-timeout report.
module hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_ID,
  input  logic [31:0]      inst_EX,
  input  logic             RegWEn_EX,
  input  WBSel_t           WBSel_EX,
  input  logic             PCSel_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  logic [6:0] opc_id;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       load_use, freeze;
  logic       stall_inc, flush_inc;

  hz_state_t        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  logic unused_inst;
  assign unused_inst = ^{inst_ID[31:25], inst_ID[14:7], inst_EX[31:12], inst_EX[6:0]};

  assign opc_id = inst_ID[6:0];
  assign rs1_id = inst_ID[19:15];
  assign rs2_id = inst_ID[24:20];
  assign rd_ex  = inst_EX[11:7];

  assign load_use = RegWEn_EX && (WBSel_EX == WB_MEM) && (rd_ex != '0) &&
                    ((uses_rs1(opc_id) && (rs1_id == rd_ex)) ||
                     (uses_rs2(opc_id) && (rs2_id == rd_ex)));

  assign freeze = dmem_req_MEM && !dmem_ready;

  // Priority: reset, memory freeze, redirect, load-use bubble.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_en    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    EX_MEM_en   = 1'b1;
    MEM_WB_en   = 1'b1;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_en    = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (freeze) begin
      PCWrite   = 1'b0;
      IF_ID_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (PCSel_EX) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PCWrite     = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  assign stall_inc = !rst && (freeze || (load_use && !PCSel_EX));
  assign flush_inc = !rst && !freeze && PCSel_EX;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      HZ_RUN: begin
        if (freeze) begin
          state_d = HZ_MEM_WAIT;
          wait_d  = '0;
        end
      end
      HZ_MEM_WAIT: begin
        if (wait_q != WaitMax) begin
          wait_d = wait_q + WaitW'(1);
        end
        if (!freeze) begin
          state_d = HZ_RUN;
        end
      end
    endcase
    // Report only; the freeze itself is never broken by the timeout.
    if ((state_q == HZ_MEM_WAIT) && (wait_d == WaitMax)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_inc),
    .q  (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(flush_inc),
    .q  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default-sized and a small (CNT_W=2, TIMEOUT=4) instance share
// stimulus; a behavioural model checks both every cycle, directed literals pin the model.
module tb_hazard_ctrl;
  import rv32_pkg::*;

  localparam int BT = 64;
  localparam int ST = 4;
  localparam int BMAX = 65535;
  localparam int SMAX = 3;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X5  = 32'h00228333;
  localparam logic [31:0] ADD_X0  = 32'h00200333;
  localparam logic [31:0] LUI_X5  = 32'h000282B7;
  localparam logic [31:0] ADDI_X3 = 32'h00518313;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] inst_id, inst_ex;
  logic        regwen_ex, pcsel_ex, dmem_req, dmem_ready;
  WBSel_t      wbsel_ex;

  logic        b_pcw, b_ifen, b_iff, b_idf, b_exen, b_wben, b_to;
  logic [15:0] b_stall, b_flush;
  logic        s_pcw, s_ifen, s_iff, s_idf, s_exen, s_wben, s_to;
  logic [1:0]  s_stall, s_flush;
  logic [5:0]  b_ctl, s_ctl;

  assign b_ctl = {b_pcw, b_ifen, b_iff, b_idf, b_exen, b_wben};
  assign s_ctl = {s_pcw, s_ifen, s_iff, s_idf, s_exen, s_wben};

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .inst_ID(inst_id), .inst_EX(inst_ex), .RegWEn_EX(regwen_ex),
    .WBSel_EX(wbsel_ex), .PCSel_EX(pcsel_ex), .dmem_req_MEM(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(b_pcw), .IF_ID_en(b_ifen), .IF_ID_flush(b_iff), .ID_EX_flush(b_idf),
    .EX_MEM_en(b_exen), .MEM_WB_en(b_wben), .stall_cnt(b_stall), .flush_cnt(b_flush),
    .mem_timeout(b_to)
  );

  hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_dut_s (
    .clk(clk), .rst(rst), .inst_ID(inst_id), .inst_EX(inst_ex), .RegWEn_EX(regwen_ex),
    .WBSel_EX(wbsel_ex), .PCSel_EX(pcsel_ex), .dmem_req_MEM(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(s_pcw), .IF_ID_en(s_ifen), .IF_ID_flush(s_iff), .ID_EX_flush(s_idf),
    .EX_MEM_en(s_exen), .MEM_WB_en(s_wben), .stall_cnt(s_stall), .flush_cnt(s_flush),
    .mem_timeout(s_to)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Which registers an instruction reads, straight from the ISA operand usage.
  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] op = inst[6:0];
    bit r1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    bit r2 = op inside {OP_OP, OP_STORE, OP_BRANCH};
    return (r1 && inst[19:15] == r) || (r2 && inst[24:20] == r);
  endfunction

  function automatic bit m_freeze();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit m_load_use();
    return regwen_ex && wbsel_ex == WB_MEM && inst_ex[11:7] != 5'd0 &&
           reads_reg(inst_id, inst_ex[11:7]);
  endfunction

  function automatic logic [5:0] m_ctl();
    if (rst) return 6'b001111;
    if (m_freeze()) return 6'b000000;
    if (pcsel_ex) return 6'b111111;
    if (m_load_use()) return 6'b000111;
    return 6'b110011;
  endfunction

  // Model state: counts, sticky flags, and length of the current memory-wait episode.
  int m_stall_b, m_stall_s, m_flush_b, m_flush_s, m_mw;
  bit m_to_b, m_to_s, m_in_wait, m_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("model_ctl_big", b_ctl, m_ctl());
      chk("model_ctl_small", s_ctl, m_ctl());
      if (m_valid) begin
        chk("model_stall_big", b_stall, m_stall_b);
        chk("model_stall_small", s_stall, m_stall_s);
        chk("model_flush_big", b_flush, m_flush_b);
        chk("model_flush_small", s_flush, m_flush_s);
        chk("model_to_big", b_to, m_to_b);
        chk("model_to_small", s_to, m_to_s);
      end
      if (rst) begin
        m_stall_b = 0; m_stall_s = 0; m_flush_b = 0; m_flush_s = 0;
        m_mw = 0; m_to_b = 0; m_to_s = 0; m_in_wait = 0; m_valid = 1;
      end else begin
        if (m_freeze() || (m_load_use() && !pcsel_ex)) begin
          m_stall_b = (m_stall_b < BMAX) ? m_stall_b + 1 : BMAX;
          m_stall_s = (m_stall_s < SMAX) ? m_stall_s + 1 : SMAX;
        end
        if (pcsel_ex && !m_freeze()) begin
          m_flush_b = (m_flush_b < BMAX) ? m_flush_b + 1 : BMAX;
          m_flush_s = (m_flush_s < SMAX) ? m_flush_s + 1 : SMAX;
        end
        if (m_in_wait) begin
          m_mw++;
          if (m_mw >= BT) m_to_b = 1;
          if (m_mw >= ST) m_to_s = 1;
        end else begin
          m_mw = 0;
        end
        m_in_wait = m_freeze();
      end
    end
  end

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  function automatic logic [31:0] rand_inst();
    logic [31:0] x = $urandom;
    x[6:0]   = ops[$urandom_range(0, 8)];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic idle();
    rst = 0; inst_id = NOP_INST; inst_ex = NOP_INST; regwen_ex = 0; wbsel_ex = WB_ALU;
    pcsel_ex = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic lw5();
    idle(); inst_ex = LW_X5; regwen_ex = 1; wbsel_ex = WB_MEM;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int frz_left = 0;

  initial begin
    idle(); rst = 1;
    @(negedge clk); chk("rst_ctl", b_ctl, 6'b001111); chk("rst_ctl_small", s_ctl, 6'b001111);
    nxt(); idle();
    @(negedge clk); chk("idle_ctl", b_ctl, 6'b110011); chk("rst_stall", b_stall, 0);
    chk("rst_flush", b_flush, 0); chk("rst_to", s_to, 0);
    nxt(); lw5(); inst_id = ADD_X5;
    @(negedge clk); chk("lu_ctl", b_ctl, 6'b000111);
    nxt(); idle();
    @(negedge clk); chk("lu_stall", b_stall, 1); chk("lu_one_bubble", b_ctl, 6'b110011);
    nxt(); lw5(); inst_ex = LW_X0; inst_id = ADD_X0;
    @(negedge clk); chk("x0_nohz", b_ctl, 6'b110011);
    nxt(); lw5(); inst_id = LUI_X5;
    @(negedge clk); chk("lui_nohz", b_ctl, 6'b110011);
    nxt(); lw5(); inst_id = ADDI_X3;
    @(negedge clk); chk("addi_nohz", b_ctl, 6'b110011);
    nxt(); idle();
    @(negedge clk); chk("nohz_stall", b_stall, 1);
    nxt(); lw5(); inst_id = ADD_X5; pcsel_ex = 1;
    @(negedge clk); chk("redir_ctl", b_ctl, 6'b111111);
    nxt(); idle();
    @(negedge clk); chk("redir_flush", b_flush, 1); chk("redir_stall", b_stall, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); idle(); dmem_req = 1; pcsel_ex = 1;
      @(negedge clk); chk("frz_ctl", b_ctl, 6'b000000);
    end
    nxt(); idle(); dmem_req = 1; dmem_ready = 1; pcsel_ex = 1;
    @(negedge clk); chk("release_ctl", b_ctl, 6'b111111);
    nxt(); idle();
    @(negedge clk); chk("frz_stall", b_stall, 4); chk("frz_flush", b_flush, 2);
    chk("sat_stall_small", s_stall, 3); chk("flush_small", s_flush, 2); chk("no_to", s_to, 0);
    for (int i = 0; i < 6; i++) begin
      nxt(); idle(); dmem_req = 1;
      @(negedge clk); chk("to_rise_small", s_to, (i == 5) ? 1 : 0);
    end
    nxt(); idle(); dmem_req = 1; dmem_ready = 1;
    @(negedge clk); chk("to_sticky_ready", s_to, 1); chk("to_big_clear", b_to, 0);
    nxt(); idle(); pcsel_ex = 1;
    nxt(); idle(); pcsel_ex = 1;
    nxt(); idle();
    @(negedge clk); chk("to_sticky", s_to, 1); chk("sat_flush_small", s_flush, 3);
    chk("flush_big", b_flush, 4);
    nxt(); idle(); dmem_req = 1;
    nxt(); idle(); dmem_req = 1;
    nxt(); idle(); dmem_req = 1; rst = 1;
    @(negedge clk); chk("rst_frz_ctl", b_ctl, 6'b001111);
    nxt(); idle();
    @(negedge clk); chk("rst_frz_stall", b_stall, 0); chk("rst_frz_stall_s", s_stall, 0);
    chk("rst_frz_to", s_to, 0); chk("rst_frz_flush", b_flush, 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); idle(); dmem_req = 1;
      @(negedge clk); chk("rewait_to", s_to, 0);
    end
    nxt(); idle(); dmem_req = 1; dmem_ready = 1;
    @(negedge clk); chk("rewait_to_set", s_to, 1);

    repeat (4000) begin
      nxt();
      rst = ($urandom_range(0, 149) == 0);
      inst_id = rand_inst();
      inst_ex = rand_inst();
      regwen_ex = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: wbsel_ex = WB_ALU;
        1: wbsel_ex = WB_PC4;
        default: wbsel_ex = WB_MEM;
      endcase
      pcsel_ex = ($urandom_range(0, 4) == 0);
      if (frz_left > 0) begin
        frz_left--;
        dmem_req = 1; dmem_ready = 0;
      end else begin
        if ($urandom_range(0, 299) == 0) frz_left = 70;
        dmem_req = ($urandom_range(0, 2) == 0);
        dmem_ready = 1'($urandom_range(0, 1));
      end
    end
    nxt(); idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
